pipe_sqrt_csla: RTL and testbench

- Parametrised, pipelined square-root carry-select adder/subtractor with BEC-1 select logic.
- Successor to the fixed 32-bit combinational sqrt CSLA: generalised in WIDTH and pipeline depth, with add/sub mode, signed-overflow flag and a valid/ready handshake.
- Serves as the wide-add building block for the recursive Karatsuba multiplier's partial-product combination stages.

---
 rtl/pipe_sqrt_csla.sv | 180 ++++++++++++++++++
 tb/tb_pipe_sqrt_csla.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sqrt_csla.sv
// Pipelined square-root carry-select adder/subtractor (RCA + BEC-1 groups), WIDTH bits, STAGES register stages.
// Latency STAGES cycles from accept; whole pipe stalls while out_valid && !out_ready, in_ready = !out_valid || out_ready.
module pipe_sqrt_csla #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    // Group g starts at bit grp_lo(g); sizes run 2,2,3,4,5,...
    function automatic int grp_lo(input int g);
        int lo;
        lo = 0;
        for (int j = 0; j < g; j++) lo += (j == 0) ? 2 : j + 1;
        return lo;
    endfunction

    function automatic int grp_hi(input int g);
        int hi;
        hi = grp_lo(g + 1);
        return (hi < WIDTH) ? hi : WIDTH;
    endfunction

    function automatic int num_groups(input int w);
        int n;
        n = 0;
        while (grp_lo(n) < w) n++;
        return n;
    endfunction

    localparam int NGROUPS = num_groups(WIDTH);

    // Earlier segments absorb the remainder groups.
    function automatic int seg_first(input int i);
        int base, rem;
        base = NGROUPS / STAGES;
        rem  = NGROUPS % STAGES;
        return i * base + ((i < rem) ? i : rem);
    endfunction

    function automatic int bit_lo(input int i);
        int lo;
        lo = grp_lo(seg_first(i));
        return (lo < WIDTH) ? lo : WIDTH;
    endfunction

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~y : y;
    assign cin_eff  = sub | cin;

    for (genvar i = 0; i < STAGES; i++) begin : stg
        localparam int GF = seg_first(i);
        localparam int GN = seg_first(i + 1) - GF;
        localparam int LO = bit_lo(i);
        localparam int HI = bit_lo(i + 1);
        localparam int SW = HI - LO;

        logic [WIDTH-1:0]    d_in;
        logic [WIDTH-1:0]    d_nxt;
        logic [WIDTH-1:0]    d_q;
        logic [WIDTH-LO-1:0] bh_in;
        logic                c_in;
        logic                v_in;
        logic                c_q;
        logic                v_q;
        logic [SW-1:0]       ssum;
        logic [SW-1:0]       t0;
        logic [SW-1:0]       t1;
        logic                cr;
        logic                rc;
        logic                pa;
        logic                ab;
        logic                bb;
        logic                sel;

        if (i == 0) begin : g_src
            assign d_in  = x;
            assign bh_in = b_eff;
            assign c_in  = cin_eff;
            assign v_in  = in_valid;
        end else begin : g_src
            assign d_in  = stg[i-1].d_q;
            assign bh_in = stg[i-1].g_fwd.b_q;
            assign c_in  = stg[i-1].c_q;
            assign v_in  = stg[i-1].v_q;
        end

        // t0: ripple sum with carry-in 0 (group 0 takes the real carry); t1: BEC-1 of t0.
        always_comb begin
            cr   = c_in;
            rc   = 1'b0;
            pa   = 1'b1;
            ab   = 1'b0;
            bb   = 1'b0;
            sel  = 1'b0;
            t0   = '0;
            t1   = '0;
            ssum = '0;
            for (int j = 0; j < GN; j++) begin
                rc = (GF + j == 0) ? cr : 1'b0;
                pa = 1'b1;
                for (int k = grp_lo(GF + j) - LO; k < grp_hi(GF + j) - LO; k++) begin
                    ab    = d_in[LO + k];
                    bb    = bh_in[k];
                    t0[k] = ab ^ bb ^ rc;
                    rc    = (ab & bb) | (rc & (ab ^ bb));
                    t1[k] = t0[k] ^ pa;
                    pa    = pa & t0[k];
                end
                sel = cr && (GF + j != 0);
                for (int k = grp_lo(GF + j) - LO; k < grp_hi(GF + j) - LO; k++) begin
                    ssum[k] = sel ? t1[k] : t0[k];
                end
                cr = sel ? (rc | pa) : rc;
            end
        end

        always_comb begin
            d_nxt        = d_in;
            d_nxt[HI-1:LO] = ssum;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance) begin
                d_q <= d_nxt;
                c_q <= cr;
                v_q <= v_in;
            end
        end

        if (i < STAGES - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b_q <= '0;
                end else if (advance) begin
                    b_q <= bh_in[WIDTH-LO-1:SW];
                end
            end
        end else begin : g_out
            logic ovf_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= (d_in[WIDTH-1] == bh_in[WIDTH-LO-1]) && (ssum[SW-1] != d_in[WIDTH-1]);
                end
            end

            assign s         = d_q;
            assign cout      = c_q;
            assign out_valid = v_q;
            assign ovf       = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipe_sqrt_csla.sv
// Directed and reference-model checks of pipe_sqrt_csla at 32/2, 16/1 and 64/4.
module tb_pipe_sqrt_csla;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_cin, a_sub, a_out_valid, a_out_ready, a_cout, a_ovf;
    logic [31:0] a_x, a_y, a_s;
    logic        b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready, b_cout, b_ovf;
    logic [15:0] b_x, b_y, b_s;
    logic        c_in_valid, c_in_ready, c_cin, c_sub, c_out_valid, c_out_ready, c_cout, c_ovf;
    logic [63:0] c_x, c_y, c_s;

    pipe_sqrt_csla #(.WIDTH(32), .STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x(a_x), .y(a_y), .cin(a_cin), .sub(a_sub),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .s(a_s), .cout(a_cout), .ovf(a_ovf)
    );

    pipe_sqrt_csla #(.WIDTH(16), .STAGES(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .y(b_y), .cin(b_cin), .sub(b_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .s(b_s), .cout(b_cout), .ovf(b_ovf)
    );

    pipe_sqrt_csla #(.WIDTH(64), .STAGES(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .x(c_x), .y(c_y), .cin(c_cin), .sub(c_sub),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .s(c_s), .cout(c_cout), .ovf(c_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic run_a(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                         input logic ci, input logic sb,
                         input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        a_x = xv; a_y = yv; a_cin = ci; a_sub = sb; a_in_valid = 1'b1;
        chk({tag, "_in_ready"}, a_in_ready, 1);
        tick;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 10) begin
            tick;
            lat++;
        end
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_s"}, a_s, es);
        chk({tag, "_cout"}, a_cout, ec);
        chk({tag, "_ovf"}, a_ovf, eo);
    endtask

    task automatic run_b(input logic [15:0] xv, input logic [15:0] yv, input logic ci, input logic sb);
        int                lat;
        logic signed [17:0] r;
        logic [16:0]        u;
        r = sb ? ($signed(xv) - $signed(yv)) : ($signed(xv) + $signed(yv) + $signed({1'b0, ci}));
        u = {1'b0, xv} + {1'b0, yv} + {16'd0, ci};
        b_x = xv; b_y = yv; b_cin = ci; b_sub = sb; b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 10) begin
            tick;
            lat++;
        end
        chk("w16_latency", lat, 1);
        chk("w16_s", b_s, r[15:0]);
        chk("w16_cout", b_cout, sb ? (xv >= yv) : u[16]);
        chk("w16_ovf", b_ovf, !((r[17:15] == 3'b000) || (r[17:15] == 3'b111)));
    endtask

    task automatic run_c(input logic [63:0] xv, input logic [63:0] yv, input logic ci, input logic sb);
        int                 lat;
        logic signed [65:0] r;
        logic [64:0]        u;
        r = sb ? ($signed(xv) - $signed(yv)) : ($signed(xv) + $signed(yv) + $signed({1'b0, ci}));
        u = {1'b0, xv} + {1'b0, yv} + {64'd0, ci};
        c_x = xv; c_y = yv; c_cin = ci; c_sub = sb; c_in_valid = 1'b1;
        tick;
        c_in_valid = 1'b0;
        lat = 1;
        while (!c_out_valid && lat < 12) begin
            tick;
            lat++;
        end
        chk("w64_latency", lat, 4);
        chk("w64_s", c_s, r[63:0]);
        chk("w64_cout", c_cout, sb ? (xv >= yv) : u[64]);
        chk("w64_ovf", c_ovf, !((r[65:63] == 3'b000) || (r[65:63] == 3'b111)));
    endtask

    initial begin
        a_in_valid = 0; a_x = '0; a_y = '0; a_cin = 0; a_sub = 0; a_out_ready = 1;
        b_in_valid = 0; b_x = '0; b_y = '0; b_cin = 0; b_sub = 0; b_out_ready = 1;
        c_in_valid = 0; c_x = '0; c_y = '0; c_cin = 0; c_sub = 0; c_out_ready = 1;

        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_s", a_s, 0);
        chk("rst_cout", a_cout, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_w64_out_valid", c_out_valid, 0);
        #1 rst = 1'b0;
        tick;

        run_a("double", 32'h42884743, 32'h42884743, 1'b0, 1'b0, 32'h85108E86, 1'b0, 1'b1);
        run_a("add_cin", 32'hF28A47B3, 32'h4B8B47A3, 1'b1, 1'b0, 32'h3E158F57, 1'b1, 1'b0);
        run_a("sub_pos", 32'd5, 32'd3, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
        run_a("sub_neg", 32'd3, 32'd5, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_a("add_ovf", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_a("sub_ovf", 32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_a("wrap", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);

        // Backpressure: four beats, out_ready low for three cycles once the first result shows.
        a_cin = 0; a_sub = 0;
        a_x = 32'd1; a_y = 32'd1; a_in_valid = 1'b1;
        tick;
        a_x = 32'd2; a_y = 32'd2;
        tick;
        chk("bp_first_vld", a_out_valid, 1);
        chk("bp_first_s", a_s, 2);
        a_out_ready = 1'b0;
        a_x = 32'd3; a_y = 32'd3;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_stall_in_ready", a_in_ready, 0);
            chk("bp_stall_vld", a_out_valid, 1);
            chk("bp_stall_s", a_s, 2);
            tick;
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", a_in_ready, 1);
        chk("bp_release_s", a_s, 2);
        tick;
        chk("bp_second_vld", a_out_valid, 1);
        chk("bp_second_s", a_s, 4);
        a_x = 32'd4; a_y = 32'd4;
        tick;
        chk("bp_third_vld", a_out_valid, 1);
        chk("bp_third_s", a_s, 6);
        a_in_valid = 1'b0;
        tick;
        chk("bp_fourth_vld", a_out_valid, 1);
        chk("bp_fourth_s", a_s, 8);
        tick;
        chk("bp_drained_vld", a_out_valid, 0);

        // Reset with two beats in flight.
        a_x = 32'd10; a_y = 32'd10; a_in_valid = 1'b1;
        tick;
        a_x = 32'd20; a_y = 32'd20;
        tick;
        chk("flight_vld", a_out_valid, 1);
        chk("flight_s", a_s, 20);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_s", a_s, 0);
        chk("midrst_cout", a_cout, 0);
        chk("midrst_in_ready", a_in_ready, 1);
        a_in_valid = 1'b0;
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("postrst_no_stale", a_out_valid, 0);
        end

        run_b(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_b(16'h8000, 16'h0001, 1'b1, 1'b1);
        run_b(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        for (int n = 0; n < 12; n++) begin
            run_b(16'($urandom), 16'($urandom), n[0], n[1]);
        end

        run_c(64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 1'b0);
        run_c(64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b0, 1'b1);
        run_c(64'h7FFFFFFFFFFFFFFF, 64'd0, 1'b1, 1'b0);
        for (int n = 0; n < 12; n++) begin
            run_c({$urandom, $urandom}, {$urandom, $urandom}, n[0], n[1]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
